sorter_2b_3b: RTL and testbench



---
 rtl/sorter_2b_3b_if.sv | 21 ++
 rtl/sorter_2b_3b.sv | 73 +++++++
 tb/tb_sorter_2b_3b.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sorter_2b_3b_if.sv
// Request/result bundle for the 2-bit / 3-bit bit sorter.
// The master drives x/in_valid; the slave (the sorter) returns the registered results.
interface sorter_2b_3b_if;
  logic       in_valid;
  logic [2:0] x;
  logic       out_valid;
  logic [1:0] y2b;
  logic [2:0] y3b;
  logic [1:0] cnt2b;
  logic [1:0] cnt3b;

  modport master (
    output in_valid, x,
    input  out_valid, y2b, y3b, cnt2b, cnt3b
  );

  modport slave (
    input  in_valid, x,
    output out_valid, y2b, y3b, cnt2b, cnt3b
  );
endinterface

// File: rtl/sorter_2b_3b.sv
// Registered bit sorter: thermometer sorts of x[1:0] and x[2:0] plus their popcounts.
// One-cycle latency, one result per cycle, no back-pressure. All outputs are flops.
module sorter_2b_3b (
  input  logic           clk,
  input  logic           rst_n,
  sorter_2b_3b_if.slave  bus
);

  // Two-bit thermometer: OR on the low bit, AND on the high bit.
  function automatic logic [1:0] therm2(input logic [1:0] v);
    therm2 = {v[0] & v[1], v[0] | v[1]};
  endfunction

  // Three-bit thermometer: OR, majority, AND.
  function automatic logic [2:0] therm3(input logic [2:0] v);
    therm3 = {v[0] & v[1] & v[2],
              (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]),
              v[0] | v[1] | v[2]};
  endfunction

  function automatic logic [1:0] pop2(input logic [1:0] v);
    pop2 = {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

  function automatic logic [1:0] pop3(input logic [2:0] v);
    pop3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  logic       out_valid_d, out_valid_q;
  logic [1:0] y2b_d, y2b_q;
  logic [2:0] y3b_d, y3b_q;
  logic [1:0] cnt2b_d, cnt2b_q;
  logic [1:0] cnt3b_d, cnt3b_q;

  // Next state: load from x only when qualified, otherwise hold so x is never observed.
  always_comb begin
    out_valid_d = bus.in_valid;
    y2b_d       = y2b_q;
    y3b_d       = y3b_q;
    cnt2b_d     = cnt2b_q;
    cnt3b_d     = cnt3b_q;
    if (bus.in_valid) begin
      y2b_d   = therm2(bus.x[1:0]);
      y3b_d   = therm3(bus.x);
      cnt2b_d = pop2(bus.x[1:0]);
      cnt3b_d = pop3(bus.x);
    end
  end

  // Output register; reset clears results and wins over in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y2b_q       <= 2'b00;
      y3b_q       <= 3'b000;
      cnt2b_q     <= 2'd0;
      cnt3b_q     <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      y2b_q       <= y2b_d;
      y3b_q       <= y3b_d;
      cnt2b_q     <= cnt2b_d;
      cnt3b_q     <= cnt3b_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y2b       = y2b_q;
  assign bus.y3b       = y3b_q;
  assign bus.cnt2b     = cnt2b_q;
  assign bus.cnt3b     = cnt3b_q;

endmodule

// File: tb/tb_sorter_2b_3b.sv
// Self-checking bench for sorter_2b_3b using a scoreboard queue of expected results.
module tb_sorter_2b_3b;

  typedef struct packed {
    logic [1:0] y2;
    logic [2:0] y3;
    logic [1:0] c2;
    logic [1:0] c3;
  } exp_t;

  logic clk;
  logic rst_n;
  sorter_2b_3b_if bus();

  sorter_2b_3b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  exp_t held;
  exp_t want;
  exp_t got;

  // Reference model: count ones, thermometer = (1 << n) - 1.
  function automatic exp_t model(input logic [2:0] xi);
    int   n2;
    int   n3;
    exp_t e;
    n2 = int'(xi[0]) + int'(xi[1]);
    n3 = n2 + int'(xi[2]);
    e.y2 = 2'((1 << n2) - 1);
    e.y3 = 3'((1 << n3) - 1);
    e.c2 = 2'(n2);
    e.c3 = 2'(n3);
    return e;
  endfunction

  // Drive one cycle at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic rst_v, input logic v, input logic [2:0] xi);
    @(negedge clk);
    rst_n        = rst_v;
    bus.in_valid = v;
    bus.x        = xi;
    if (v && rst_v) exp_q.push_back(model(xi));
    @(posedge clk);
    #1;
    got = {bus.y2b, bus.y3b, bus.cnt2b, bus.cnt3b};
  endtask

  // Take the next expected result; an empty scoreboard is itself a failure.
  task automatic pop_exp();
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty: got size 0 required >0");
      want = held;
    end else begin
      want = exp_q.pop_front();
      held = want;
    end
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 3'b111);
    step(1'b0, 1'b1, 3'b111);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b required 0", bus.out_valid);
    end
    n_tests++;
    if (got !== '0) begin
      n_fail++; $display("FAIL reset_data: got %b required %b", got, 9'b0);
    end
    held = '0;
    step(1'b1, 1'b1, 3'b111);
    n_tests++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_valid: got %b required 1", bus.out_valid);
    end
    pop_exp();
    n_tests++;
    if (got !== want || bus.y3b !== 3'b111 || bus.y2b !== 2'b11) begin
      n_fail++; $display("FAIL reset_release_data: got %b required %b", got, want);
    end
  endtask

  task automatic test_sweep();
    logic [2:0] y3_tab [8] = '{3'b000, 3'b001, 3'b001, 3'b011, 3'b001, 3'b011, 3'b011, 3'b111};
    logic [1:0] y2_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 3'(i));
      pop_exp();
      n_tests++;
      if (bus.out_valid !== 1'b1 || got !== want) begin
        n_fail++;
        $display("FAIL sweep_x%0d: got v=%b %b required v=1 %b", i, bus.out_valid, got, want);
      end
      n_tests++;
      if (bus.y3b !== y3_tab[i] || bus.y2b !== y2_tab[i]) begin
        n_fail++;
        $display("FAIL sweep_table_x%0d: got %b/%b required %b/%b",
                 i, bus.y3b, bus.y2b, y3_tab[i], y2_tab[i]);
      end
    end
  endtask

  task automatic test_permutation();
    logic [2:0] xs  [3] = '{3'b001, 3'b010, 3'b100};
    logic [1:0] y2s [3] = '{2'b01, 2'b01, 2'b00};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, xs[i]);
      pop_exp();
      n_tests++;
      if (got !== want || bus.y3b !== 3'b001 || bus.y2b !== y2s[i]) begin
        n_fail++;
        $display("FAIL perm_%b: got %b required %b (y3b 001, y2b %b)", xs[i], got, want, y2s[i]);
      end
    end
  endtask

  task automatic test_hold();
    step(1'b1, 1'b1, 3'b011);
    pop_exp();
    n_tests++;
    if (bus.out_valid !== 1'b1 || got !== want) begin
      n_fail++; $display("FAIL hold_load: got v=%b %b required v=1 %b", bus.out_valid, got, want);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, (i == 1) ? 3'b111 : 3'b000);
      n_tests++;
      if (bus.out_valid !== 1'b0 || got !== held || bus.y3b !== 3'b011 || bus.y2b !== 2'b11) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got v=%b %b required v=0 %b", i, bus.out_valid, got, held);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, (i % 2 == 0) ? 3'b111 : 3'b000);
      pop_exp();
      n_tests++;
      if (bus.out_valid !== 1'b1 || got !== want) begin
        n_fail++;
        $display("FAIL b2b_%0d: got v=%b %b required v=1 %b", i, bus.out_valid, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    step(1'b1, 1'b1, 3'b101);
    pop_exp();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.y3b !== 3'b011 || got !== want) begin
      n_fail++; $display("FAIL mid_pre: got v=%b %b required v=1 %b", bus.out_valid, got, want);
    end
    step(1'b0, 1'b1, 3'b111);
    n_tests++;
    if (bus.out_valid !== 1'b0 || got !== '0) begin
      n_fail++; $display("FAIL mid_reset: got v=%b %b required v=0 0", bus.out_valid, got);
    end
    held = '0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 3'b101);
      n_tests++;
      if (bus.out_valid !== 1'b0 || got !== '0) begin
        n_fail++; $display("FAIL mid_stale%0d: got v=%b %b required v=0 0", i, bus.out_valid, got);
      end
    end
    step(1'b1, 1'b1, 3'b110);
    pop_exp();
    n_tests++;
    if (bus.out_valid !== 1'b1 || got !== want) begin
      n_fail++; $display("FAIL mid_resume: got v=%b %b required v=1 %b", bus.out_valid, got, want);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.x        = 3'b000;
    held         = '0;
    test_reset();
    test_sweep();
    test_permutation();
    test_hold();
    test_back_to_back();
    test_reset_mid_stream();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
